// File: rtl/neuron_pkg.sv
// Shared fixed-point definitions for the neuron/synapse datapaths.
//   WIDTH_DEF / FR_WIDTH_DEF : default signed fixed-point format (1.0 = 2^FR_WIDTH_DEF)
//   fix_t                    : default-width signed fixed-point value
//   sat_add                  : add two values and clamp the result to a signed
//                              range of the given bit width
package neuron_pkg;

    localparam int WIDTH_DEF    = 20;
    localparam int FR_WIDTH_DEF = 11;

    typedef logic signed [WIDTH_DEF-1:0] fix_t;

    // Operands are carried at 64 bits so callers of any width up to 62 bits
    // can sign-extend into it without overflow; the result is clamped to
    // [-2^(width-1), 2^(width-1)-1] and the caller truncates back to width.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        width
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        else
            return s;
    endfunction

endpackage

// File: rtl/spike_delay_ring.sv
// Axonal delay line for one synapse, built as a ring of one-bit arrival slots.
//   clk, reset : clock and synchronous active-high reset
//   spike_in   : presynaptic spike, sampled each rising edge
//   delay      : delay for the spike sampled this edge (clamped to DELAY_MAX)
//   arrive     : combinational, slot under the read pointer (arrives this edge)
//   pending    : registered, 1 while any slot is occupied
//   collision  : registered pulse, new spike landed on an occupied slot
module spike_delay_ring #(
    parameter  int DELAY_MAX = 15,
    localparam int DW        = $clog2(DELAY_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spike_in,
    input  logic [DW-1:0] delay,
    output logic          arrive,
    output logic          pending,
    output logic          collision
);

    // One extra slot beyond DELAY_MAX+1 keeps the write target distinct from
    // the slot being read and cleared on the same edge.
    localparam int DEPTH = DELAY_MAX + 2;
    localparam int PW    = $clog2(DEPTH);

    localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [DW-1:0] DMAX    = DW'(DELAY_MAX);

    logic [DEPTH-1:0] slots;
    logic [DEPTH-1:0] slots_nx;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nx;
    logic [PW-1:0]    tgt;
    logic [PW:0]      tsum;
    logic [DW-1:0]    dly;
    logic             coll_nx;

    always_comb begin
        dly      = (delay > DMAX) ? DMAX : delay;
        tsum     = (PW + 1)'(ptr) + (PW + 1)'(dly) + (PW + 1)'(1);
        tgt      = (tsum >= DEPTH_W) ? PW'(tsum - DEPTH_W) : PW'(tsum);
        ptr_nx   = (ptr == LAST) ? '0 : ptr + PW'(1);
        arrive   = slots[ptr];

        slots_nx      = slots;
        slots_nx[ptr] = 1'b0;
        coll_nx       = 1'b0;
        if (spike_in) begin
            coll_nx       = slots[tgt];
            slots_nx[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slots     <= '0;
            ptr       <= '0;
            pending   <= 1'b0;
            collision <= 1'b0;
        end else begin
            slots     <= slots_nx;
            ptr       <= ptr_nx;
            pending   <= |slots_nx;
            collision <= coll_nx;
        end
    end

endmodule

// File: rtl/spike_synapse.sv
// Single synapse: delays a presynaptic spike, then adds a signed weight into an
// exponentially decaying synaptic current.
//   clk, reset : clock and synchronous active-high reset
//   spike_in   : presynaptic spike (upstream synout)
//   weight     : signed fixed-point weight, read on the arrival edge
//   delay      : axonal delay captured with each spike
//   isyn       : registered synaptic current (downstream synin)
//   pending    : registered, 1 while any spike is in flight
//   collision  : registered pulse, two spikes merged into one arrival
module spike_synapse
    import neuron_pkg::*;
#(
    parameter  int WIDTH       = WIDTH_DEF,
    parameter  int FR_WIDTH    = FR_WIDTH_DEF,
    parameter  int DELAY_MAX   = 15,
    parameter  int DECAY_SHIFT = 4,
    localparam int DW          = $clog2(DELAY_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spike_in,
    input  logic signed [WIDTH-1:0] weight,
    input  logic        [DW-1:0]    delay,
    output logic signed [WIDTH-1:0] isyn,
    output logic                    pending,
    output logic                    collision
);

    if (FR_WIDTH < 0 || FR_WIDTH >= WIDTH) begin : g_bad_format
        $error("spike_synapse: FR_WIDTH must lie in [0, WIDTH-1]");
    end

    localparam int AW = WIDTH + 2;
    localparam logic signed [AW-1:0] ONE_A = AW'(1);
    // Bias added before the arithmetic shift of a negative value so the
    // quotient truncates toward zero instead of toward minus infinity.
    localparam logic signed [AW-1:0] RND   = AW'((1 << DECAY_SHIFT) - 1);

    logic                    arrive;
    logic signed [AW-1:0]    cur;
    logic signed [AW-1:0]    dec;
    logic signed [AW-1:0]    add;
    logic signed [AW-1:0]    acc;
    logic signed [WIDTH-1:0] isyn_nx;

    spike_delay_ring #(
        .DELAY_MAX (DELAY_MAX)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .spike_in  (spike_in),
        .delay     (delay),
        .arrive    (arrive),
        .pending   (pending),
        .collision (collision)
    );

    always_comb begin
        cur = AW'(isyn);
        if (isyn[WIDTH-1])
            dec = (cur + RND) >>> DECAY_SHIFT;
        else
            dec = cur >>> DECAY_SHIFT;
        // Small magnitudes would otherwise stall above zero forever.
        if (dec == '0 && isyn != '0)
            dec = isyn[WIDTH-1] ? -ONE_A : ONE_A;
        add     = arrive ? AW'(weight) : '0;
        acc     = cur - dec + add;
        isyn_nx = WIDTH'(sat_add(64'(acc), 64'sd0, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset)
            isyn <= '0;
        else
            isyn <= isyn_nx;
    end

endmodule

// File: tb/tb_spike_synapse.sv
module tb_spike_synapse;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               spike_in = 1'b0;
    logic signed [19:0] weight = '0;
    logic        [3:0]  delay = '0;
    logic signed [19:0] isyn;
    logic               pending;
    logic               collision;

    int errors = 0;
    int checks = 0;

    spike_synapse dut (
        .clk       (clk),
        .reset     (reset),
        .spike_in  (spike_in),
        .weight    (weight),
        .delay     (delay),
        .isyn      (isyn),
        .pending   (pending),
        .collision (collision)
    );

    always #5 clk = ~clk;

    // Reference model: arrivals are kept as absolute edge numbers.
    int     n = 0;
    longint m_isyn = 0;
    bit     m_pend = 0;
    bit     m_coll = 0;
    bit     sched[int];

    task automatic model_edge();
        longint d;
        longint v;
        int     t;
        bit     arr;
        if (reset) begin
            m_isyn = 0;
            m_pend = 0;
            m_coll = 0;
            sched.delete();
        end else begin
            arr = sched.exists(n);
            if (arr) sched.delete(n);
            d = m_isyn / 16;
            if (d == 0 && m_isyn != 0) d = (m_isyn > 0) ? 1 : -1;
            v = m_isyn - d + (arr ? longint'(weight) : 0);
            if (v > 524287) v = 524287;
            else if (v < -524288) v = -524288;
            m_coll = 0;
            if (spike_in) begin
                t = n + ((delay > 15) ? 15 : int'(delay)) + 1;
                m_coll = sched.exists(t);
                sched[t] = 1;
            end
            m_isyn = v;
            m_pend = (sched.size() > 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spike_in = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        spike_in = 1'b1;
        weight = 20'sd2048;
        delay = 4'd0;
        step();
        step();
        reset = 1'b0;
        spike_in = 1'b0;
        checks++;
        if (isyn !== 20'sd0 || pending !== 1'b0 || collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: isyn=%0d pending=%b collision=%b, want 0 0 0", isyn, pending, collision);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (isyn !== 20'sd0 || pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_arrival: cycle %0d isyn=%0d pending=%b, want 0 0", i, isyn, pending);
            end
        end
    endtask

    task automatic test_single();
        logic signed [19:0] exp_tail [3] = '{20'sd2048, 20'sd1920, 20'sd1800};
        do_reset();
        weight = 20'sd2048;
        delay = 4'd3;
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (isyn !== 20'sd0 || pending !== 1'b1) begin
                errors++;
                $display("FAIL single_wait: k+%0d isyn=%0d pending=%b, want 0 1", i, isyn, pending);
            end
            if (i < 3) step();
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (isyn !== exp_tail[i] || pending !== 1'b0) begin
                errors++;
                $display("FAIL single_arrive: k+%0d isyn=%0d pending=%b, want %0d 0", i + 4, isyn, pending, exp_tail[i]);
            end
        end
    endtask

    task automatic test_tail();
        do_reset();
        weight = 20'sd15;
        delay = 4'd0;
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        for (int v = 15; v >= 0; v--) begin
            step();
            checks++;
            if (isyn !== 20'(v)) begin
                errors++;
                $display("FAIL tail_pos: isyn=%0d want %0d", isyn, v);
            end
        end
        step();
        step();
        checks++;
        if (isyn !== 20'sd0) begin
            errors++;
            $display("FAIL tail_pos_hold: isyn=%0d want 0", isyn);
        end
        weight = -20'sd20;
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        for (int v = -20; v <= 0; v++) begin
            step();
            checks++;
            if (isyn !== 20'(v) || isyn !== 20'(m_isyn)) begin
                errors++;
                $display("FAIL tail_neg: isyn=%0d want %0d", isyn, v);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        weight = 20'sd524287;
        delay = 4'd0;
        spike_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (isyn !== 20'(m_isyn)) begin
                errors++;
                $display("FAIL sat_pos_model: isyn=%0d want %0d", isyn, m_isyn);
            end
        end
        checks++;
        if (isyn !== 20'sd524287) begin
            errors++;
            $display("FAIL sat_pos: isyn=%0d want 524287", isyn);
        end
        weight = -20'sd524288;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (isyn !== 20'(m_isyn)) begin
                errors++;
                $display("FAIL sat_neg_model: isyn=%0d want %0d", isyn, m_isyn);
            end
        end
        checks++;
        if (isyn !== -20'sd524288) begin
            errors++;
            $display("FAIL sat_neg: isyn=%0d want -524288", isyn);
        end
        spike_in = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        weight = 20'sd2048;
        delay = 4'd3;
        spike_in = 1'b1;
        step();
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_early: collision=%b want 0", collision);
        end
        delay = 4'd2;
        step();
        spike_in = 1'b0;
        checks++;
        if (collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_pulse: collision=%b want 1", collision);
        end
        step();
        step();
        checks++;
        if (collision !== 1'b0 || isyn !== 20'sd0) begin
            errors++;
            $display("FAIL coll_after: collision=%b isyn=%0d want 0 0", collision, isyn);
        end
        step();
        checks++;
        if (isyn !== 20'sd2048 || pending !== 1'b0) begin
            errors++;
            $display("FAIL coll_arrive: isyn=%0d pending=%b want 2048 0", isyn, pending);
        end
        step();
        checks++;
        if (isyn !== 20'sd1920) begin
            errors++;
            $display("FAIL coll_single_add: isyn=%0d want 1920", isyn);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        weight = 20'sd100;
        delay = 4'd2;
        spike_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) spike_in = 1'b0;
            step();
            checks++;
            if (isyn !== 20'(m_isyn) || collision !== 1'b0 || pending !== m_pend) begin
                errors++;
                $display("FAIL b2b: cycle %0d isyn=%0d coll=%b pend=%b want %0d 0 %b", i, isyn, collision, pending, m_isyn, m_pend);
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        weight = 20'sd2048;
        delay = 4'd10;
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pending: pending=%b want 1", pending);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (isyn !== 20'sd0 || pending !== 1'b0) begin
                errors++;
                $display("FAIL midflight_flush: cycle %0d isyn=%0d pending=%b want 0 0", i, isyn, pending);
            end
            step();
        end
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            spike_in = ($urandom_range(0, 2) == 0);
            delay = 4'($urandom_range(0, 15));
            w = int'($urandom_range(0, 8191)) - 4096;
            if ($urandom_range(0, 19) == 0) w = ($urandom_range(0, 1) == 1) ? 524287 : -524288;
            weight = w[19:0];
            reset = ($urandom_range(0, 149) == 0);
            step();
            checks++;
            if (isyn !== 20'(m_isyn) || pending !== m_pend || collision !== m_coll) begin
                errors++;
                $display("FAIL random: cycle %0d isyn=%0d pend=%b coll=%b want %0d %b %b", i, isyn, pending, collision, m_isyn, m_pend, m_coll);
            end
        end
        reset = 1'b0;
        spike_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tail();
        test_saturation();
        test_collision();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
